// File: rtl/adc_scan_sched.sv
// rtl/adc_scan_sched.sv - periodic multi-channel ADC scan scheduler with valid/ready sample output
module adc_scan_sched #(
    parameter int PERIOD  = 50000,
    parameter int TIMEOUT = 1024,
    parameter int CH_W    = 3
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iEN,
    input  logic [2**CH_W-1:0]   iCH_MASK,
    output logic                 oCONV_GO,
    output logic [CH_W-1:0]      oCONV_CH,
    input  logic                 iCONV_DONE,
    input  logic [11:0]          iCONV_DATA,
    output logic                 oVALID,
    input  logic                 iREADY,
    output logic [11:0]          oDATA,
    output logic [CH_W-1:0]      oCH,
    output logic                 oFIRST,
    output logic                 oLAST,
    output logic                 oBUSY,
    output logic                 oOVERRUN,
    output logic                 oTIMEOUT
);

    localparam int NCH   = 2**CH_W;
    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_START,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [NCH-1:0]   rem_q, rem_d;
    logic [CH_W-1:0]  conv_ch_q, conv_ch_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [11:0]      data_q, data_d;
    logic [CH_W-1:0]  och_q, och_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             first_pend_q, first_pend_d;
    logic             is_first_q, is_first_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic [CH_W-1:0]  low_ch;
    logic             low_found;

    // Tick strobe is registered so it lands exactly PERIOD cycles after iEN rises.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (iEN) begin
            if (cnt_q == CNT_MAX) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Lowest set bit of the remaining mask wins.
    always_comb begin
        low_ch    = '0;
        low_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                low_ch    = CH_W'(i);
                low_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        conv_ch_d    = conv_ch_q;
        wait_d       = wait_q;
        data_d       = data_q;
        och_d        = och_q;
        first_d      = first_q;
        last_d       = last_q;
        first_pend_d = first_pend_q;
        is_first_d   = is_first_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        if (tick_q && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_q && (iCH_MASK != '0)) begin
                    rem_d        = iCH_MASK;
                    first_pend_d = 1'b1;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!low_found) begin
                    state_d = S_IDLE;
                end else begin
                    conv_ch_d    = low_ch;
                    rem_d        = rem_q & ~(NCH'(1) << low_ch);
                    is_first_d   = first_pend_q;
                    first_pend_d = 1'b0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iCONV_DONE) begin
                    data_d  = iCONV_DATA;
                    och_d   = conv_ch_q;
                    first_d = is_first_q;
                    last_d  = (rem_q == '0);
                    state_d = S_PUSH;
                end else if (wait_q == TO_MAX) begin
                    // Channel is dropped; the scan carries on with the rest.
                    timeout_d = 1'b1;
                    state_d   = S_SCAN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_PUSH: begin
                if (iREADY) begin
                    state_d = S_SCAN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            rem_q        <= '0;
            conv_ch_q    <= '0;
            wait_q       <= '0;
            data_q       <= '0;
            och_q        <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            first_pend_q <= 1'b0;
            is_first_q   <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            rem_q        <= rem_d;
            conv_ch_q    <= conv_ch_d;
            wait_q       <= wait_d;
            data_q       <= data_d;
            och_q        <= och_d;
            first_q      <= first_d;
            last_q       <= last_d;
            first_pend_q <= first_pend_d;
            is_first_q   <= is_first_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign oCONV_GO = (state_q == S_START);
    assign oCONV_CH = conv_ch_q;
    assign oVALID   = (state_q == S_PUSH);
    assign oDATA    = data_q;
    assign oCH      = och_q;
    assign oFIRST   = first_q;
    assign oLAST    = last_q;
    assign oBUSY    = (state_q != S_IDLE);
    assign oOVERRUN = overrun_q;
    assign oTIMEOUT = timeout_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// tb/tb_adc_scan_sched.sv - directed bench for adc_scan_sched with a behavioural conversion engine
module tb_adc_scan_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  mask;
    logic        go;
    logic [2:0]  conv_ch;
    logic        done;
    logic [11:0] cdata;
    logic        valid;
    logic        ready;
    logic [11:0] data;
    logic [2:0]  ch;
    logic        first;
    logic        last;
    logic        busy;
    logic        overrun;
    logic        tmo;

    int n_checks = 0;
    int n_fail   = 0;
    int eng_lat  = 20;
    int drop_ch  = -1;
    int eng_cnt;
    int eng_ch;
    bit eng_busy;
    int k;
    bit stable;
    bit go_seen;
    bit idle_ok;

    adc_scan_sched #(
        .PERIOD (200),
        .TIMEOUT(64),
        .CH_W   (3)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iEN       (en),
        .iCH_MASK  (mask),
        .oCONV_GO  (go),
        .oCONV_CH  (conv_ch),
        .iCONV_DONE(done),
        .iCONV_DATA(cdata),
        .oVALID    (valid),
        .iREADY    (ready),
        .oDATA     (data),
        .oCH       (ch),
        .oFIRST    (first),
        .oLAST     (last),
        .oBUSY     (busy),
        .oOVERRUN  (overrun),
        .oTIMEOUT  (tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine answers eng_lat cycles after a start with 0x100+channel, or never for drop_ch.
    initial begin
        done     = 1'b0;
        cdata    = '0;
        eng_busy = 1'b0;
        eng_cnt  = 0;
        eng_ch   = 0;
        forever begin
            @(posedge clk);
            #1;
            done = 1'b0;
            if (eng_busy) begin
                eng_cnt++;
                if (eng_cnt == eng_lat) begin
                    eng_busy = 1'b0;
                    if (eng_ch != drop_ch) begin
                        done  = 1'b1;
                        cdata = 12'h100 + 12'(eng_ch);
                    end
                end
            end
            if (go) begin
                eng_busy = 1'b1;
                eng_cnt  = 0;
                eng_ch   = int'(conv_ch);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < budget);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    task automatic wait_go(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!go && n < budget);
        chk({tag, "_go"}, 32'(go), 32'd1);
    endtask

    task automatic check_sample(input string tag, input int exp_ch, input bit f, input bit l);
        chk({tag, "_ch"},    32'(ch),    32'(exp_ch));
        chk({tag, "_data"},  32'(data),  32'h100 + 32'(exp_ch));
        chk({tag, "_first"}, 32'(first), 32'(f));
        chk({tag, "_last"},  32'(last),  32'(l));
    endtask

    task automatic count_to_go(output int n, input int budget);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!go && n < budget);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        mask  = 8'h00;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid",   32'(valid),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_go",      32'(go),      32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(tmo),     32'd0);
        chk("rst_data",    32'(data),    32'd0);
        chk("rst_convch",  32'(conv_ch), 32'd0);

        // Basic scan of mask A5: tick at cycle 200, start pulse two cycles later.
        rst  = 1'b0;
        en   = 1'b1;
        mask = 8'hA5;
        count_to_go(k, 400);
        chk("tick_to_go", 32'(k), 32'd202);
        chk("first_go_ch", 32'(conv_ch), 32'd0);
        wait_valid("s1a", 100); check_sample("s1a", 0, 1'b1, 1'b0);
        wait_valid("s1b", 100); check_sample("s1b", 2, 1'b0, 1'b0);
        wait_valid("s1c", 100); check_sample("s1c", 5, 1'b0, 1'b0);
        wait_valid("s1d", 100); check_sample("s1d", 7, 1'b0, 1'b1);
        chk("s1_overrun", 32'(overrun), 32'd0);
        chk("s1_timeout", 32'(tmo),     32'd0);

        // Backpressure on ch2 for 50 cycles.
        wait_valid("s2a", 300); check_sample("s2a", 0, 1'b1, 1'b0);
        @(negedge clk);
        ready = 1'b0;
        wait_valid("s2b", 100); check_sample("s2b", 2, 1'b0, 1'b0);
        stable  = 1'b1;
        go_seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (!(valid && data == 12'h102 && ch == 3'd2 && !first && !last)) stable = 1'b0;
            if (go) go_seen = 1'b1;
        end
        chk("bp_hold_stable", 32'(stable),  32'd1);
        chk("bp_no_go",       32'(go_seen), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_acc_valid", 32'(valid), 32'd0);
        chk("bp_acc_go",    32'(go),    32'd0);
        @(negedge clk);
        chk("bp_go_ch5",    32'(go),      32'd1);
        chk("bp_go_ch5_ch", 32'(conv_ch), 32'd5);
        wait_valid("s2c", 100); check_sample("s2c", 5, 1'b0, 1'b0);
        wait_valid("s2d", 100); check_sample("s2d", 7, 1'b0, 1'b1);

        // Engine never answers ch2: 64-cycle wait, then ch5 starts.
        drop_ch = 2;
        wait_valid("s3a", 300); check_sample("s3a", 0, 1'b1, 1'b0);
        chk("s3_timeout_pre", 32'(tmo), 32'd0);
        wait_go("s3_ch2", 10);
        chk("s3_go_ch2", 32'(conv_ch), 32'd2);
        count_to_go(k, 200);
        chk("s3_gap", 32'(k), 32'd66);
        chk("s3_go_ch5", 32'(conv_ch), 32'd5);
        chk("s3_timeout_set", 32'(tmo), 32'd1);
        wait_valid("s3c", 100); check_sample("s3c", 5, 1'b0, 1'b0);
        wait_valid("s3d", 100); check_sample("s3d", 7, 1'b0, 1'b1);

        // Slow engine on 4 channels overruns the period; mask change mid-scan ignored.
        drop_ch = -1;
        eng_lat = 60;
        mask    = 8'h0F;
        wait_valid("s4a", 300); check_sample("s4a", 0, 1'b1, 1'b0);
        chk("s4_overrun_pre", 32'(overrun), 32'd0);
        wait_valid("s4b", 100); check_sample("s4b", 1, 1'b0, 1'b0);
        mask = 8'h00;
        wait_valid("s4c", 100); check_sample("s4c", 2, 1'b0, 1'b0);
        wait_valid("s4d", 100); check_sample("s4d", 3, 1'b0, 1'b1);
        chk("s4_overrun_set", 32'(overrun), 32'd1);
        chk("s4_timeout_sticky", 32'(tmo), 32'd1);

        // Three ticks with a zero mask must not start anything.
        repeat (3) @(negedge clk);
        idle_ok = 1'b1;
        repeat (590) begin
            @(negedge clk);
            if (go || busy) idle_ok = 1'b0;
        end
        chk("zero_mask_idle", 32'(idle_ok), 32'd1);
        mask    = 8'h80;
        eng_lat = 20;
        ready   = 1'b0;
        wait_valid("s5", 300); check_sample("s5", 7, 1'b1, 1'b1);
        @(negedge clk);
        chk("s5_held", 32'(valid), 32'd1);

        // Reset while stalled in PUSH.
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_valid",   32'(valid),   32'd0);
        chk("rst2_busy",    32'(busy),    32'd0);
        chk("rst2_overrun", 32'(overrun), 32'd0);
        chk("rst2_timeout", 32'(tmo),     32'd0);
        chk("rst2_data",    32'(data),    32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        count_to_go(k, 400);
        chk("rst2_tick_to_go", 32'(k), 32'd202);
        chk("rst2_go_ch", 32'(conv_ch), 32'd7);
        wait_valid("s6", 100); check_sample("s6", 7, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
